// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared control-word indices, funct3 codes and FSM states for the load/store unit
package lsu_pkg;

  localparam int MEMREAD  = 0;
  localparam int MEMWRITE = 1;
  localparam int F3_LO    = 2;
  localparam int F3_HI    = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: store enables/replication and load select/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_f3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_f3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'd0, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit: req/ack data-memory transaction with stall and fault flags
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int size     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] FU_i,
  input  logic [size-1:0] RAM_DATA_i,
  input  logic [11:0]     Control_Signal_i,
  output logic            mem_req,
  output logic            mem_we,
  output logic [size-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [size-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [size-1:0] mem_rdata,
  output logic            stall_o,
  output logic [size-1:0] load_data_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic [7:0]  r_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_load_data;
  logic        r_bus_err;
  logic [2:0]  r_f3;
  logic [1:0]  r_addr_lo;

  logic        w_mread;
  logic        w_mwrite;
  logic [2:0]  w_f3;
  logic        w_any;
  logic        w_valid;
  logic        w_bad_f3;
  logic        w_misal;
  logic        w_legal;
  logic        w_launch;
  logic        w_ack_hit;
  logic        w_timeout;

  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;
  logic [31:0] w_unused_st_rdata;
  logic [3:0]  w_unused_ld_be;
  logic [31:0] w_unused_ld_wdata;
  logic [6:0]  w_unused_ctrl_hi;

  assign w_unused_ctrl_hi = Control_Signal_i[11:5];

  assign w_mread  = Control_Signal_i[MEMREAD];
  assign w_mwrite = Control_Signal_i[MEMWRITE];
  assign w_f3     = Control_Signal_i[F3_HI:F3_LO];
  assign w_any    = w_mread | w_mwrite;
  assign w_valid  = w_mread ^ w_mwrite;

  assign w_bad_f3 = w_mread ? (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                            : (w_f3 > F3_W);
  assign w_misal  = (w_f3[1:0] == 2'b01 && FU_i[0]) ||
                    (w_f3[1:0] == 2'b10 && FU_i[1:0] != 2'b00);
  assign w_legal  = w_valid && !w_bad_f3 && !w_misal;

  lsu_align u_store_align (
    .i_f3      (w_f3),
    .i_addr_lo (FU_i[1:0]),
    .i_wdata   (RAM_DATA_i),
    .i_rdata   (mem_rdata),
    .o_be      (w_st_be),
    .o_wdata   (w_st_wdata),
    .o_rdata   (w_unused_st_rdata)
  );

  // Load path uses the attributes latched at launch, since EX/MEM may be reused by then.
  lsu_align u_load_align (
    .i_f3      (r_f3),
    .i_addr_lo (r_addr_lo),
    .i_wdata   (32'd0),
    .i_rdata   (mem_rdata),
    .o_be      (w_unused_ld_be),
    .o_wdata   (w_unused_ld_wdata),
    .o_rdata   (w_ld_data)
  );

  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_ack_hit  = 1'b0;
    w_timeout  = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (r_state)
      IDLE: begin
        stall_o    = w_legal;
        misalign_o = w_any && !w_legal;
        if (w_legal) begin
          w_launch = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          w_ack_hit = 1'b1;
          w_next    = DONE;
        end else if (r_cnt == LP_LAST_WAIT) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_load_data <= 32'd0;
      r_bus_err   <= 1'b0;
      r_f3        <= 3'd0;
      r_addr_lo   <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_bus_err <= w_timeout;
      if (w_launch) begin
        r_cnt       <= 8'd0;
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_mwrite;
        r_mem_addr  <= {FU_i[31:2], 2'b00};
        r_mem_be    <= w_st_be;
        r_mem_wdata <= w_st_wdata;
        r_f3        <= w_f3;
        r_addr_lo   <= FU_i[1:0];
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_ack_hit) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) begin
          r_load_data <= w_ld_data;
        end
      end
      if (w_timeout) begin
        r_mem_req   <= 1'b0;
        r_load_data <= 32'd0;
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_be      = r_mem_be;
  assign mem_wdata   = r_mem_wdata;
  assign load_data_o = r_load_data;
  assign bus_err_o   = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam int LP_MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic [31:0] FU_i;
  logic [31:0] RAM_DATA_i;
  logic [11:0] Control_Signal_i;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        misalign_o;
  logic        bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] ldata;
    logic        berr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_ldata;

  mem_access_unit #(.size(32), .MAX_WAIT(LP_MAX_WAIT)) dut (
    .clk              (clk),
    .reset            (reset),
    .FU_i             (FU_i),
    .RAM_DATA_i       (RAM_DATA_i),
    .Control_Signal_i (Control_Signal_i),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_be           (mem_be),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .stall_o          (stall_o),
    .load_data_o      (load_data_o),
    .misalign_o       (misalign_o),
    .bus_err_o        (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    int w    = width_of(f3);
    int base = int'(a) - (int'(a) % w);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + w);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    int w = width_of(f3);
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % w) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    int w    = width_of(f3);
    int base = int'(a) - (int'(a) % w);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < w; k++) v[8*k +: 8] = rd[8*(base+k) +: 8];
    if (!f3[2] && w < 4 && v[8*w-1]) begin
      for (int k = w; k < 4; k++) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // Entered and left just after a rising edge; ack_at = WAIT cycle carrying ack, 0 = never.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [31:0] rdata, input int ack_at, input string tag);
    exp_t e;
    int   n;
    bit   acked;
    acked   = (ack_at >= 1 && ack_at <= LP_MAX_WAIT);
    n       = acked ? ack_at : LP_MAX_WAIT;
    e.addr  = {addr[31:2], 2'b00};
    e.be    = m_be(f3, addr[1:0]);
    e.we    = wr;
    e.wdata = m_wdata(f3, rs2);
    e.berr  = !acked;
    e.ldata = !acked ? 32'd0 : (rd ? m_load(f3, addr[1:0], rdata) : last_ldata);
    last_ldata = e.ldata;
    sb.push_back(e);

    FU_i             = addr;
    RAM_DATA_i       = rs2;
    Control_Signal_i = {7'd0, f3, wr, rd};
    mem_ack          = 1'b0;
    @(negedge clk);
    check({tag, "_idle_stall"}, stall_o, 1);
    check({tag, "_idle_misal"}, misalign_o, 0);
    check({tag, "_idle_req"}, mem_req, 0);
    @(posedge clk); #1;
    for (int c = 1; c <= n; c++) begin
      mem_ack   = (c == ack_at);
      mem_rdata = rdata;
      @(negedge clk);
      check({tag, "_wait_req"}, mem_req, 1);
      check({tag, "_wait_stall"}, stall_o, 1);
      if (c == 1) begin
        check({tag, "_addr"}, mem_addr, sb[0].addr);
        check({tag, "_be"}, {28'd0, mem_be}, {28'd0, sb[0].be});
        check({tag, "_we"}, mem_we, sb[0].we);
        if (wr) check({tag, "_wdata"}, mem_wdata, sb[0].wdata);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_done_req"}, mem_req, 0);
    check({tag, "_done_stall"}, stall_o, 0);
    check({tag, "_done_ldata"}, load_data_o, e.ldata);
    check({tag, "_done_berr"}, bus_err_o, e.berr);
    @(posedge clk); #1;
    Control_Signal_i = 12'd0;
    @(negedge clk);
    check({tag, "_post_req"}, mem_req, 0);
    check({tag, "_post_berr"}, bus_err_o, 0);
    check({tag, "_post_stall"}, stall_o, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_illegal(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input string tag);
    FU_i             = addr;
    RAM_DATA_i       = 32'hA5A5_A5A5;
    Control_Signal_i = {7'd0, f3, wr, rd};
    mem_ack          = 1'b1;
    @(negedge clk);
    check({tag, "_misal"}, misalign_o, 1);
    check({tag, "_stall"}, stall_o, 0);
    check({tag, "_req"}, mem_req, 0);
    @(posedge clk); #1;
    Control_Signal_i = 12'd0;
    mem_ack          = 1'b0;
    @(negedge clk);
    check({tag, "_noreq"}, mem_req, 0);
    check({tag, "_misal_clr"}, misalign_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset            = 1'b0;
    FU_i             = 32'd0;
    RAM_DATA_i       = 32'd0;
    Control_Signal_i = 12'd0;
    mem_ack          = 1'b0;
    mem_rdata        = 32'd0;
    last_ldata       = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", {28'd0, mem_be}, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ldata", load_data_o, 0);
    check("rst_berr", bus_err_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_misal", misalign_o, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_access(1, 0, 3'b010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 1, "lw");
    run_access(1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 2, "lb");
    run_access(1, 0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1, "lbu");
    run_access(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, "sh");
    run_access(0, 1, 3'b000, 32'h0000_2001, 32'h0000_00EF, 32'd0, 3, "sb");
    run_access(1, 0, 3'b101, 32'h0000_3002, 32'd0, 32'h8001_7F00, 1, "lhu");
    run_access(1, 0, 3'b001, 32'h0000_3002, 32'd0, 32'h8001_7F00, 2, "lh");
    run_access(1, 0, 3'b010, 32'h0000_4000, 32'd0, 32'h1357_9BDF, LP_MAX_WAIT, "ack_at_limit");
    run_access(1, 0, 3'b010, 32'h0000_5008, 32'd0, 32'hCAFE_F00D, 0, "timeout");
    run_access(0, 1, 3'b010, 32'h0000_6000, 32'h0BAD_F00D, 32'd0, 1, "sw");

    run_illegal(1, 0, 3'b001, 32'h0000_3001, "ill_lh");
    run_illegal(1, 1, 3'b010, 32'h0000_3000, "ill_rw");
    run_illegal(1, 0, 3'b010, 32'h0000_3002, "ill_lw");
    run_illegal(0, 1, 3'b011, 32'h0000_3000, "ill_sf3");
    run_illegal(1, 0, 3'b110, 32'h0000_3000, "ill_lf3");

    for (int i = 0; i < 8; i++) begin
      logic        r;
      logic [2:0]  f;
      logic [31:0] a;
      r = 1'($urandom_range(0, 1));
      if (r) begin
        case ($urandom_range(0, 4))
          0: f = 3'b000;
          1: f = 3'b001;
          2: f = 3'b010;
          3: f = 3'b100;
          default: f = 3'b101;
        endcase
      end else begin
        f = 3'($urandom_range(0, 2));
      end
      a = $urandom;
      a = a & ~(32'(width_of(f)) - 32'd1);
      run_access(r, !r, f, a, $urandom, $urandom, $urandom_range(1, LP_MAX_WAIT), "rnd");
    end

    FU_i             = 32'h0000_7004;
    Control_Signal_i = {7'd0, 3'b010, 1'b0, 1'b1};
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("arst_pre_req", mem_req, 1);
    reset = 1'b0;
    #1;
    check("arst_req", mem_req, 0);
    Control_Signal_i = 12'd0;
    #1;
    check("arst_stall", stall_o, 0);
    check("arst_ldata", load_data_o, 0);
    @(posedge clk); #1;
    reset      = 1'b1;
    last_ldata = 32'd0;
    @(posedge clk); #1;
    run_access(1, 0, 3'b100, 32'h0000_7002, 32'd0, 32'h00C3_0000, 1, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting downstream of the EX/MEM pipeline register in the 5-stage RV32I core. It consumes the registered ALU result (effective address), store data and control word, runs a req/ack transaction on the data-memory port, and returns aligned, sign- or zero-extended load data toward MEM/WB. It holds the front of the pipeline with `stall_o` while a transaction is outstanding, and flags misaligned, illegal or timed-out accesses.

## Interface
- `size`, 32: data/address width; only 32 is supported, because byte lanes are fixed at 4.
- `MAX_WAIT`, 15: maximum cycles in WAIT without `mem_ack` before abort; range 1..255.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `FU_i` in size: effective address from EX/MEM.
- `RAM_DATA_i` in size: store data (rs2) from EX/MEM.
- `Control_Signal_i` in 12: bit0 MemRead, bit1 MemWrite, bits[4:2] funct3; other bits ignored.
- `mem_req` out 1: transaction request, registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out size: word address, {FU_i[31:2],2'b00}, registered.
- `mem_be` out 4: byte enables, registered.
- `mem_wdata` out size: lane-replicated store data, registered.
- `mem_ack` in 1: completion, valid only in WAIT.
- `mem_rdata` in size: read word, sampled with `mem_ack`.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX, EX/MEM.
- `load_data_o` out size: extended load result, registered.
- `misalign_o` out 1: misaligned/illegal access flag, combinational.
- `bus_err_o` out 1: timeout pulse, registered.

## Operation
- FSM states: IDLE, WAIT, DONE. The access is valid when exactly one of MemRead/MemWrite is set.
- IDLE, valid and legal: `stall_o`=1 combinationally. Latch the address, `mem_we`, `mem_be` and `mem_wdata`, then go to WAIT.
- IDLE, illegal access: no request, `stall_o`=0, `misalign_o`=1 for that cycle, stay in IDLE. Illegal means any of:
  - both MemRead and MemWrite set;
  - funct3 in {011,110,111} for a load, or > 010 for a store;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- WAIT: `mem_req`=1, `stall_o`=1, and the wait counter increments each cycle.
  - `mem_ack`=1: capture the extended `mem_rdata` into `load_data_o` (loads only; stores leave it unchanged), drop `mem_req`, go to DONE.
  - Counter reaches MAX_WAIT: drop `mem_req`, set `load_data_o`=0, pulse `bus_err_o` for one cycle, go to DONE.
- DONE: `stall_o`=0 so EX/MEM advances, then go to IDLE. A new access is never launched from DONE, so the same instruction is not re-issued.
- Store lanes:
  - SB: `mem_be` = 4'b0001<<addr[1:0], byte replicated ×4.
  - SH: `mem_be` = 4'b0011<<{addr[1],1'b0}, halfword replicated ×2.
  - SW: `mem_be` = 4'b1111, data unchanged.
- Load lanes:
  - LB/LBU: select byte addr[1:0], sign- or zero-extend.
  - LH/LHU: select halfword addr[1], sign- or zero-extend.
  - LW: whole word.
- For loads, `mem_be` is driven as for the equivalent store width. `mem_ack` outside WAIT is ignored.

## Timing
- Reset (`reset`=0, async): state IDLE and counter 0. `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `load_data_o` and `bus_err_o` all go to 0. `stall_o` and `misalign_o` follow their inputs from IDLE (0 while EX/MEM is also in reset).
- Reset asserted in WAIT: `mem_req` falls immediately, with no wait for a clock edge. The pending transaction is abandoned.
- Cycle N: access presented in IDLE. Cycle N+1: `mem_req`=1.
- Ack sampled at the end of cycle N+k (k≥1): DONE in N+k+1, with `load_data_o` valid and `stall_o`=0. Back in IDLE at N+k+2.
- Zero-wait memory (ack in the first WAIT cycle) gives 3 cycles per access. Minimum stall is 2 cycles.
- Ack arriving in the same cycle the counter hits MAX_WAIT: ack wins and no error is raised.

## Structure
- Package `lsu_pkg` holds:
  - control bit indices (MEMREAD=0, MEMWRITE=1, F3_LO=2, F3_HI=4);
  - funct3 constants (F3_B/H/W/BU/HU);
  - the state enum {IDLE, WAIT, DONE}.
- Sub-module `lsu_align` is combinational. It generates byte enables and replicated write data, and does the load lane-select and extension. It is instantiated once for the store path and once for the load path. FSM and counter stay in the top.

## Test plan
- LW at 0x0000_1004, ack on the 1st WAIT cycle, `mem_rdata`=0xDEAD_BEEF → `mem_addr`=0x1004, `mem_be`=1111, `load_data_o`=0xDEAD_BEEF, `stall_o` high 2 cycles.
- LB at 0x1003, `mem_rdata`=0x80FF_0000 → `load_data_o`=0xFFFF_FF80; the same with LBU → 0x0000_0080.
- SH at 0x2002, rs2=0x1234_ABCD → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCD_ABCD.
- LH at 0x3001 → `misalign_o`=1, `mem_req` stays 0, `stall_o`=0; MemRead=MemWrite=1 → same response.
- No ack, MAX_WAIT=4 → `mem_req` high 4 cycles, then `bus_err_o` pulses 1 cycle, `load_data_o`=0, IDLE 2 cycles later.
- `reset` low in the 2nd WAIT cycle → `mem_req` falls asynchronously. After release, the next access starts cleanly from IDLE.
